// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-index width and the NOP instruction word.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned RegIdxW  = 5;
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use comparator: flags a load in EX whose destination
// is read by the instruction in decode. Register x0 never hazards.
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [RegIdxW-1:0] id_rs1_i,
    input  logic [RegIdxW-1:0] id_rs2_i,
    input  logic               id_use_rs1_i,
    input  logic               id_use_rs2_i,
    input  logic [RegIdxW-1:0] ex_wa_i,
    input  logic               ex_reg_write_i,
    input  logic               ex_mem_or_reg_i,
    output logic               load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit    = (ex_wa_i == id_rs1_i) && id_use_rs1_i;
        rs2_hit    = (ex_wa_i == id_rs2_i) && id_use_rs2_i;
        load_use_o = ex_mem_or_reg_i && ex_reg_write_i && (ex_wa_i != '0) &&
                     (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller (RUN / FLUSH / MEM_WAIT) with memory timeout.
// Optional cycle counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RegIdxW-1:0] id_rs1,
    input  logic [RegIdxW-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RegIdxW-1:0] ex_wa,
    input  logic               ex_regWrite,
    input  logic               ex_memOrReg,
    input  logic               ex_redirect,
    input  logic               mem_req,
    input  logic               mem_ack,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               ifid_flush,
    output logic               idex_stall,
    output logic               idex_flush,
    output logic               exmem_stall,
    output logic               mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    localparam int unsigned CntW = ($clog2(MEM_TIMEOUT + 1) > 4) ?
                                   $clog2(MEM_TIMEOUT + 1) : 4;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic            load_use;
    logic            mem_block;
    logic            drop;
    logic            timeout;
    logic            hold;

    hazard_cmp u_hazard_cmp (
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (id_use_rs1),
        .id_use_rs2_i    (id_use_rs2),
        .ex_wa_i         (ex_wa),
        .ex_reg_write_i  (ex_regWrite),
        .ex_mem_or_reg_i (ex_memOrReg),
        .load_use_o      (load_use)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_pend_d = flush_pend_q;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_stall  = 1'b0;
        mem_err      = 1'b0;
        mem_block    = mem_req && !mem_ack;
        drop         = 1'b0;
        timeout      = 1'b0;
        hold         = 1'b0;

        if (rst) begin
            state_d      = StRun;
            wait_cnt_d   = '0;
            flush_pend_d = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else begin
            if (state_q == StMemWait) begin
                if (mem_ack) begin
                    drop = 1'b1;
                end else if (wait_cnt_q >= CntW'(MEM_TIMEOUT)) begin
                    drop    = 1'b1;
                    timeout = 1'b1;
                end
                hold = !drop;
            end else begin
                hold = mem_block;
            end

            if (hold) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                state_d     = StMemWait;
                wait_cnt_d  = wait_cnt_q + CntW'(1);
                // A FLUSH pre-empted by a memory wait still owes its IF/ID flush.
                flush_pend_d = flush_pend_q || (state_q == StFlush);
            end else begin
                mem_err      = timeout;
                wait_cnt_d   = '0;
                flush_pend_d = 1'b0;
                state_d      = StRun;
                if (ex_redirect && state_q != StFlush) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = StFlush;
                end else if (state_q == StFlush || flush_pend_q) begin
                    ifid_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
        if (ifid_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected output vectors are queued per
// step and compared mid-cycle against the combinational outputs.
module tb_pipe_hazard_ctrl;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, mem_err}
    localparam logic [6:0] ExpNone  = 7'b000_0000;
    localparam logic [6:0] ExpLu    = 7'b110_0100;
    localparam logic [6:0] ExpRedir = 7'b001_0100;
    localparam logic [6:0] ExpFlush = 7'b001_0000;
    localparam logic [6:0] ExpMw    = 7'b110_1010;
    localparam logic [6:0] ExpErr   = 7'b000_0001;
    localparam logic [6:0] ExpRst   = 7'b001_0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_wa;
    logic       id_use_rs1, id_use_rs2, ex_regWrite, ex_memOrReg;
    logic       ex_redirect, mem_req, mem_ack;
    logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic       exmem_stall, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    logic [6:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_wa       (ex_wa),
        .ex_regWrite (ex_regWrite),
        .ex_memOrReg (ex_memOrReg),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_stall  (idex_stall),
        .idex_flush  (idex_flush),
        .exmem_stall (exmem_stall),
        .mem_err     (mem_err)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    // Inputs are already applied; queue the expectation, sample mid-cycle, advance.
    task automatic step(input logic [6:0] expv, input string tag);
        logic [6:0] obs;
        logic [6:0] want;
        exp_q.push_back(expv);
        #3;
        obs  = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, mem_err};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazard();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_wa = 5'd0; ex_regWrite = 1'b0; ex_memOrReg = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_hazard();
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
        #1;
        step(ExpRst, "reset0");
        step(ExpRst, "reset1");
        rst = 1'b0;
        step(ExpNone, "idle");

        // Load x5 in EX, decode reads rs1=x5
        ex_memOrReg = 1'b1; ex_regWrite = 1'b1; ex_wa = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step(ExpLu, "lu_rs1");
        clear_hazard();
        step(ExpNone, "lu_clear");
        ex_memOrReg = 1'b1; ex_regWrite = 1'b1; ex_wa = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        step(ExpLu, "lu_rs2");
        id_use_rs2 = 1'b0;
        step(ExpNone, "lu_rs2_unused");
        ex_wa = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step(ExpNone, "lu_x0");
        ex_wa = 5'd9; id_rs1 = 5'd9; ex_regWrite = 1'b0;
        step(ExpNone, "lu_no_write");
        ex_regWrite = 1'b1; ex_memOrReg = 1'b0;
        step(ExpNone, "lu_not_load");

        // Redirect outranks load-use; hazard ignored in FLUSH
        ex_memOrReg = 1'b1; ex_redirect = 1'b1;
        step(ExpRedir, "redir");
        ex_redirect = 1'b0;
        step(ExpFlush, "flush_state");
        clear_hazard();
        step(ExpNone, "after_flush");

        // Memory wait acked after three stall cycles
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step(ExpMw, "mem_wait");
        mem_ack = 1'b1;
        step(ExpNone, "mem_ack");
        mem_req = 1'b0; mem_ack = 1'b0;
        step(ExpNone, "mem_idle");

        // Memory never acks: 15 stall cycles then one mem_err pulse
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) step(ExpMw, "timeout_wait");
        step(ExpErr, "timeout_err");
        mem_req = 1'b0;
        step(ExpNone, "timeout_after");

        // Redirect held across a memory wait fires on the ack cycle
        mem_req = 1'b1; ex_redirect = 1'b1;
        step(ExpMw, "redir_mw0");
        step(ExpMw, "redir_mw1");
        mem_ack = 1'b1;
        step(ExpRedir, "redir_on_ack");
        mem_req = 1'b0; mem_ack = 1'b0; ex_redirect = 1'b0;
        step(ExpFlush, "redir_flush");
        step(ExpNone, "redir_done");

        // FLUSH interrupted by a memory wait still flushes IF/ID afterwards
        ex_redirect = 1'b1;
        step(ExpRedir, "pend_redir");
        ex_redirect = 1'b0; mem_req = 1'b1;
        step(ExpMw, "pend_mw");
        mem_ack = 1'b1;
        step(ExpFlush, "pend_flush");
        mem_req = 1'b0; mem_ack = 1'b0;
        step(ExpNone, "pend_done");

        // Load-use seen on the cycle the memory wait ends
        mem_req = 1'b1;
        step(ExpMw, "lu_mw");
        mem_ack = 1'b1;
        ex_memOrReg = 1'b1; ex_regWrite = 1'b1; ex_wa = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        step(ExpLu, "lu_on_ack");
        clear_hazard(); mem_req = 1'b0; mem_ack = 1'b0;
        step(ExpNone, "lu_ack_done");

        // Reset mid-MEM_WAIT and mid-FLUSH
        mem_req = 1'b1;
        step(ExpMw, "rst_mw0");
        step(ExpMw, "rst_mw1");
        rst = 1'b1;
        step(ExpRst, "rst_in_mw");
        rst = 1'b0; mem_req = 1'b0;
        step(ExpNone, "rst_mw_after");
        ex_redirect = 1'b1;
        step(ExpRedir, "rst_fl_redir");
        ex_redirect = 1'b0; rst = 1'b1;
        step(ExpRst, "rst_in_flush");
        rst = 1'b0;
        step(ExpNone, "rst_fl_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles on a data-memory access before abort.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_rs1, id_rs2  in  5 each  decode-stage source registers.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  decode instruction reads rs1/rs2.
REQ-006 SHALL have ports ex_wa  in  5, ex_regWrite  in  1, ex_memOrReg  in  1  ID/EX register outputs.
REQ-007 SHALL have port ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-008 SHALL have ports mem_req  in  1, mem_ack  in  1  data-memory access handshake.
REQ-009 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall  out  1 each.
REQ-010 SHALL have output mem_err  out  1  one-cycle pulse on memory timeout.

Function
REQ-011 SHALL implement FSM states RUN, FLUSH, MEM_WAIT; outputs are combinational decodes of state and inputs.
REQ-012 Load-use hazard SHALL be ex_memOrReg & ex_regWrite & ex_wa!=0 & ((ex_wa==id_rs1 & id_use_rs1) | (ex_wa==id_rs2 & id_use_rs2)).
REQ-013 In RUN with load-use hazard only: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly that cycle; state stays RUN.
REQ-014 In RUN with ex_redirect (no mem wait): ifid_flush=1, idex_flush=1; next state FLUSH.
REQ-015 In FLUSH: ifid_flush=1 for one cycle; next state RUN; load-use hazard ignored in FLUSH.
REQ-016 In any state, mem_req & !mem_ack SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall that cycle; next state MEM_WAIT.
REQ-017 In MEM_WAIT: all four stalls held; 4-bit-minimum wait counter increments per cycle; mem_ack -> stalls drop that cycle, next state RUN.
REQ-018 Wait counter reaching MEM_TIMEOUT SHALL pulse mem_err one cycle, drop stalls, next state RUN, counter cleared.
REQ-019 Priority: memory wait > redirect > load-use; redirect during MEM_WAIT SHALL be acted on in the cycle stalls drop.
REQ-020 A stall and a flush SHALL never be asserted together for the same pipeline register.
REQ-021 ex_wa==0 SHALL never create a hazard.

Reset
REQ-022 While rst=1: state RUN, counters 0, ifid_flush=1, idex_flush=1, all stalls 0, mem_err 0.
REQ-023 rst mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation with no mem_err pulse.

Configuration
REQ-024 With PIPE_HAZARD_PERF_EN defined: 32-bit outputs stall_cnt and flush_cnt count cycles with pc_stall=1 and with ifid_flush=1, saturating, cleared by rst.
REQ-025 Without PIPE_HAZARD_PERF_EN: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, NOP encoding 32'h00000013, and register-index width 5.
REQ-027 Sub-module hazard_cmp (combinational load-use comparator) SHALL be instantiated once; timeout counter stays inline.

Verification
REQ-028 Load x5 in EX (memOrReg=1,regWrite=1,wa=5), decode uses rs1=5 -> one cycle pc_stall=ifid_stall=idex_flush=1, then clear.
REQ-029 ex_redirect=1 one cycle in RUN -> ifid_flush=1 two cycles, idex_flush=1 first cycle only.
REQ-030 mem_req=1, mem_ack after 3 cycles -> exmem_stall=1 cycles 0..2, low on ack cycle, state RUN.
REQ-031 mem_req=1, mem_ack never -> mem_err pulse after MEM_TIMEOUT=15 wait cycles, stalls drop same cycle.
REQ-032 Load-use with ex_wa=0 -> no stall; redirect held during MEM_WAIT -> flushes issued on ack cycle.
REQ-033 rst asserted mid-MEM_WAIT -> stalls 0, both flushes 1, no mem_err.
